// File: rtl/fwd_pipeline_cpu.sv
// fwd_pipeline_cpu: 5-stage MIPS-subset pipeline; fetch-to-retire 4 cycles unstalled; RAW hazards hold PC and IF/ID and bubble ID/EX.
// Define CPU_FWD_EN for EX forwarding (only load-use stalls, 1 cycle); otherwise ID waits until producers reach WB.
module fwd_pipeline_cpu #(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              retire_valid,
  output logic [4:0]        retire_dst,
  output logic [DATA_W-1:0] retire_data,
  output logic [31:0]       stall_count
);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       use_imm;
    alu_op_t    alu_op;
    logic [4:0] dst;
  } ctrl_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [4:0]        dst;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] store_data;
  } mem_stage_t;

  typedef struct packed {
    logic              reg_write;
    logic [4:0]        dst;
    logic [DATA_W-1:0] data;
  } wb_stage_t;

  logic [PC_W-1:0]   pc;
  logic [31:0]       ifid_instr;
  ctrl_t             idex_ctrl;
  logic [DATA_W-1:0] idex_a, idex_b, idex_imm;
  logic [4:0]        idex_shamt;
`ifdef CPU_FWD_EN
  logic [4:0]        idex_rs, idex_rt;
`endif
  mem_stage_t        exmem;
  wb_stage_t         memwb;
  logic [DATA_W-1:0] rf [32];

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd, shamt;
  logic [DATA_W-1:0] imm_ext, rs_val, rt_val;
  ctrl_t             dec;
  logic              stall;
  logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_res, wb_data;

  assign op      = ifid_instr[31:26];
  assign rs      = ifid_instr[25:21];
  assign rt      = ifid_instr[20:16];
  assign rd      = ifid_instr[15:11];
  assign shamt   = ifid_instr[10:6];
  assign funct   = ifid_instr[5:0];
  assign imm_ext = DATA_W'($signed(ifid_instr[15:0]));

  always_comb begin
    dec = '0;
    case (op)
      6'h00: begin
        dec.reg_write = 1'b1;
        dec.dst       = rd;
        case (funct)
          6'h20:   dec.alu_op = ALU_ADD;
          6'h22:   dec.alu_op = ALU_SUB;
          6'h24:   dec.alu_op = ALU_AND;
          6'h25:   dec.alu_op = ALU_OR;
          6'h2A:   dec.alu_op = ALU_SLT;
          6'h00:   dec.alu_op = ALU_SLL;
          6'h02:   dec.alu_op = ALU_SRL;
          default: dec = '0;
        endcase
      end
      6'h08: begin dec.reg_write = 1'b1; dec.use_imm = 1'b1; dec.dst = rt; end
      6'h23: begin dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.use_imm = 1'b1; dec.dst = rt; end
      6'h2B: begin dec.mem_write = 1'b1; dec.use_imm = 1'b1; end
      default: dec = '0;
    endcase
    // $0 destinations never write, so they can never forward or stall
    if (dec.dst == 5'd0) dec.reg_write = 1'b0;
  end

  // rf[0] is never written, so $0 always reads as zero
  always_comb begin
    rs_val = rf[rs];
    rt_val = rf[rt];
    if (memwb.reg_write && memwb.dst == rs) rs_val = memwb.data;
    if (memwb.reg_write && memwb.dst == rt) rt_val = memwb.data;
  end

`ifdef CPU_FWD_EN
  assign stall = idex_ctrl.mem_read && idex_ctrl.reg_write &&
                 (idex_ctrl.dst == rs || idex_ctrl.dst == rt);

  always_comb begin
    fwd_a = idex_a;
    fwd_b = idex_b;
    if (exmem.reg_write && exmem.dst == idex_rs)      fwd_a = exmem.alu_res;
    else if (memwb.reg_write && memwb.dst == idex_rs) fwd_a = memwb.data;
    if (exmem.reg_write && exmem.dst == idex_rt)      fwd_b = exmem.alu_res;
    else if (memwb.reg_write && memwb.dst == idex_rt) fwd_b = memwb.data;
  end
`else
  assign stall = (idex_ctrl.reg_write && (idex_ctrl.dst == rs || idex_ctrl.dst == rt)) ||
                 (exmem.reg_write && (exmem.dst == rs || exmem.dst == rt));
  assign fwd_a = idex_a;
  assign fwd_b = idex_b;
`endif

  always_comb begin
    alu_b = idex_ctrl.use_imm ? idex_imm : fwd_b;
    case (idex_ctrl.alu_op)
      ALU_SUB: alu_res = fwd_a - alu_b;
      ALU_AND: alu_res = fwd_a & alu_b;
      ALU_OR:  alu_res = fwd_a | alu_b;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
      ALU_SLL: alu_res = alu_b << idex_shamt;
      ALU_SRL: alu_res = alu_b >> idex_shamt;
      default: alu_res = fwd_a + alu_b;
    endcase
  end

  assign wb_data = exmem.mem_read ? dmem_rdata : exmem.alu_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= PC_RESET;
      ifid_instr  <= '0;
      idex_ctrl   <= '0;
      idex_a      <= '0;
      idex_b      <= '0;
      idex_imm    <= '0;
      idex_shamt  <= '0;
`ifdef CPU_FWD_EN
      idex_rs     <= '0;
      idex_rt     <= '0;
`endif
      exmem       <= '0;
      memwb       <= '0;
      stall_count <= '0;
    end else begin
      if (!stall) begin
        pc         <= pc + PC_W'(4);
        ifid_instr <= imem_rdata;
      end
      idex_ctrl  <= stall ? ctrl_t'('0) : dec;
      idex_a     <= rs_val;
      idex_b     <= rt_val;
      idex_imm   <= imm_ext;
      idex_shamt <= shamt;
`ifdef CPU_FWD_EN
      idex_rs    <= rs;
      idex_rt    <= rt;
`endif
      exmem.reg_write  <= idex_ctrl.reg_write;
      exmem.mem_read   <= idex_ctrl.mem_read;
      exmem.mem_write  <= idex_ctrl.mem_write;
      exmem.dst        <= idex_ctrl.dst;
      exmem.alu_res    <= alu_res;
      exmem.store_data <= fwd_b;
      memwb.reg_write  <= exmem.reg_write;
      memwb.dst        <= exmem.dst;
      memwb.data       <= wb_data;
      if (stall && stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (memwb.reg_write) begin
      rf[memwb.dst] <= memwb.data;
    end
  end

  assign imem_addr    = pc;
  assign dmem_addr    = exmem.alu_res;
  assign dmem_wdata   = exmem.store_data;
  assign dmem_we      = exmem.mem_write;
  assign dmem_re      = exmem.mem_read;
  assign retire_valid = memwb.reg_write;
  assign retire_dst   = memwb.dst;
  assign retire_data  = memwb.data;

endmodule

// File: tb/tb_fwd_pipeline_cpu.sv
// Directed bench for fwd_pipeline_cpu with behavioural instruction/data memories and a retire/store monitor.
module tb_fwd_pipeline_cpu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, retire_data, stall_count;
  logic        dmem_we, dmem_re, retire_valid;
  logic [4:0]  retire_dst;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  logic [4:0]  q_dst[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];
  logic [31:0] s_addr[$];
  logic [31:0] s_data[$];
  int          s_cyc[$];

  fwd_pipeline_cpu dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re),
    .dmem_rdata(dmem_rdata),
    .retire_valid(retire_valid), .retire_dst(retire_dst), .retire_data(retire_data),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr[9:2]];
  assign dmem_rdata = dmem[dmem_addr[9:2]];

  always @(posedge clk) if (dmem_we === 1'b1) dmem[dmem_addr[9:2]] <= dmem_wdata;

  // cyc == k during the k-th cycle after reset release (instruction at PC_RESET fetched in cycle 0)
  always @(posedge clk) if (rst) cyc <= 0; else cyc <= cyc + 1;

  always @(negedge clk) begin
    if (retire_valid === 1'b1) begin
      q_dst.push_back(retire_dst); q_data.push_back(retire_data); q_cyc.push_back(cyc);
    end
    if (dmem_we === 1'b1) begin
      s_addr.push_back(dmem_addr); s_data.push_back(dmem_wdata); s_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin imem[i] = '0; dmem[i] = '0; end
  endtask

  task automatic clear_log();
    q_dst.delete(); q_data.delete(); q_cyc.delete();
    s_addr.delete(); s_data.delete(); s_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_log();
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_mem();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_imem_addr: got %h exp %h", imem_addr, 32'h0); end
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL rst_retire_valid: got %b exp 0", retire_valid); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL rst_dmem_we: got %b exp 0", dmem_we); end
    checks++; if (dmem_re !== 1'b0) begin errors++; $display("FAIL rst_dmem_re: got %b exp 0", dmem_re); end
    checks++; if (stall_count !== 32'h0) begin errors++; $display("FAIL rst_stall_count: got %0d exp 0", stall_count); end
    checks++; if (dmem_addr !== 32'h0) begin errors++; $display("FAIL rst_dmem_addr: got %h exp 0", dmem_addr); end
    checks++; if (retire_data !== 32'h0) begin errors++; $display("FAIL rst_retire_data: got %h exp 0", retire_data); end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_log();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL pc_seq[%0d]: got %h exp %h", k, imem_addr, 32'(4 * k)); end
      checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL no_retire[%0d]: got %b exp 0", k, retire_valid); end
    end
    checks++; if (stall_count !== 32'h0) begin errors++; $display("FAIL reset_stall_count: got %0d exp 0", stall_count); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ed[3];
    logic [31:0] ev[3];
    int          ec[3];
    int          es;
    ed = '{5'd1, 5'd2, 5'd3};
    ev = '{32'd5, 32'd10, 32'd5};
`ifdef CPU_FWD_EN
    ec = '{4, 5, 6}; es = 0;
`else
    ec = '{4, 7, 10}; es = 4;
`endif
    clear_mem();
    imem[0] = enc_i(8'h08, 0, 1, 5);
    imem[1] = enc_r(1, 1, 2, 0, 8'h20);
    imem[2] = enc_r(2, 1, 3, 0, 8'h22);
    do_reset();
    run(20);
    checks++; if (q_dst.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d exp 3", q_dst.size()); end
    for (int i = 0; i < 3 && i < q_dst.size(); i++) begin
      checks++; if (q_dst[i] !== ed[i] || q_data[i] !== ev[i]) begin errors++; $display("FAIL b2b_retire[%0d]: got $%0d=%h exp $%0d=%h", i, q_dst[i], q_data[i], ed[i], ev[i]); end
      checks++; if (q_cyc[i] != ec[i]) begin errors++; $display("FAIL b2b_cycle[%0d]: got %0d exp %0d", i, q_cyc[i], ec[i]); end
    end
    checks++; if (stall_count !== 32'(es)) begin errors++; $display("FAIL b2b_stalls: got %0d exp %0d", stall_count, es); end
  endtask

  task automatic test_load_use();
    int es, ec;
`ifdef CPU_FWD_EN
    es = 1; ec = 6;
`else
    es = 2; ec = 7;
`endif
    clear_mem();
    dmem[2] = 32'h77;
    imem[0] = enc_i(8'h23, 0, 4, 8);
    imem[1] = enc_r(4, 4, 5, 0, 8'h20);
    do_reset();
    run(20);
    checks++; if (q_dst.size() != 2) begin errors++; $display("FAIL lu_count: got %0d exp 2", q_dst.size()); end
    if (q_dst.size() >= 2) begin
      checks++; if (q_dst[0] !== 5'd4 || q_data[0] !== 32'h77) begin errors++; $display("FAIL lu_load: got $%0d=%h exp $4=77", q_dst[0], q_data[0]); end
      checks++; if (q_dst[1] !== 5'd5 || q_data[1] !== 32'hEE) begin errors++; $display("FAIL lu_use: got $%0d=%h exp $5=ee", q_dst[1], q_data[1]); end
      checks++; if (q_cyc[1] != ec) begin errors++; $display("FAIL lu_cycle: got %0d exp %0d", q_cyc[1], ec); end
    end
    checks++; if (stall_count !== 32'(es)) begin errors++; $display("FAIL lu_stalls: got %0d exp %0d", stall_count, es); end
  endtask

  task automatic test_store();
    int es, ec;
`ifdef CPU_FWD_EN
    es = 0; ec = 4;
`else
    es = 2; ec = 6;
`endif
    clear_mem();
    imem[0] = enc_i(8'h08, 0, 6, -1);
    imem[1] = enc_i(8'h2B, 0, 6, 16);
    do_reset();
    run(20);
    checks++; if (s_addr.size() != 1) begin errors++; $display("FAIL st_count: got %0d exp 1", s_addr.size()); end
    if (s_addr.size() >= 1) begin
      checks++; if (s_addr[0] !== 32'd16) begin errors++; $display("FAIL st_addr: got %h exp %h", s_addr[0], 32'd16); end
      checks++; if (s_data[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL st_data: got %h exp ffffffff", s_data[0]); end
      checks++; if (s_cyc[0] != ec) begin errors++; $display("FAIL st_cycle: got %0d exp %0d", s_cyc[0], ec); end
    end
    checks++; if (dmem[4] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL st_mem: got %h exp ffffffff", dmem[4]); end
    checks++; if (q_dst.size() != 1 || q_data[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL st_addi_retire: got %0d retires exp 1 of ffffffff", q_dst.size()); end
    checks++; if (stall_count !== 32'(es)) begin errors++; $display("FAIL st_stalls: got %0d exp %0d", stall_count, es); end
  endtask

  task automatic test_zero_reg();
    clear_mem();
    imem[0] = enc_i(8'h08, 0, 0, 9);
    imem[1] = enc_r(0, 0, 7, 0, 8'h20);
    do_reset();
    run(20);
    checks++; if (q_dst.size() != 1) begin errors++; $display("FAIL zr_count: got %0d exp 1", q_dst.size()); end
    if (q_dst.size() >= 1) begin
      checks++; if (q_dst[0] !== 5'd7 || q_data[0] !== 32'h0) begin errors++; $display("FAIL zr_retire: got $%0d=%h exp $7=0", q_dst[0], q_data[0]); end
      checks++; if (q_cyc[0] != 5) begin errors++; $display("FAIL zr_cycle: got %0d exp 5", q_cyc[0]); end
    end
    checks++; if (stall_count !== 32'h0) begin errors++; $display("FAIL zr_stalls: got %0d exp 0", stall_count); end
  endtask

  task automatic test_alu_ops();
    logic [4:0]  ed[10];
    logic [31:0] ev[10];
    ed = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd12};
    ev = '{32'hFFFF_FFFA, 32'd3, 32'd2, 32'hFFFF_FFFB, 32'd1, 32'd0, 32'h30, 32'hF, 32'hFFFF_FFFC, 32'd9};
    clear_mem();
    imem[0]  = enc_i(8'h08, 0, 1, -6);
    imem[1]  = enc_i(8'h08, 0, 2, 3);
    imem[2]  = enc_r(1, 2, 3, 0, 8'h24);
    imem[3]  = enc_r(1, 2, 4, 0, 8'h25);
    imem[4]  = enc_r(1, 2, 5, 0, 8'h2A);
    imem[5]  = enc_r(2, 1, 6, 0, 8'h2A);
    imem[6]  = enc_r(0, 2, 7, 4, 8'h00);
    imem[7]  = enc_r(0, 1, 8, 28, 8'h02);
    imem[8]  = enc_r(1, 2, 10, 0, 8'h26);
    imem[9]  = enc_i(8'h0D, 0, 11, 5);
    imem[10] = enc_i(8'h08, 1, 9, 2);
    imem[11] = enc_r(2, 1, 12, 0, 8'h22);
    do_reset();
    run(50);
    checks++; if (q_dst.size() != 10) begin errors++; $display("FAIL alu_count: got %0d exp 10", q_dst.size()); end
    for (int i = 0; i < 10 && i < q_dst.size(); i++) begin
      checks++; if (q_dst[i] !== ed[i] || q_data[i] !== ev[i]) begin errors++; $display("FAIL alu_retire[%0d]: got $%0d=%h exp $%0d=%h", i, q_dst[i], q_data[i], ed[i], ev[i]); end
    end
    checks++; if (s_addr.size() != 0) begin errors++; $display("FAIL alu_no_store: got %0d exp 0", s_addr.size()); end
  endtask

  task automatic test_reset_mid();
    clear_mem();
    dmem[9] = 32'h5A5A;
    imem[0] = enc_i(8'h08, 0, 2, 7);
    imem[1] = enc_i(8'h2B, 0, 0, 36);
    do_reset();
    run(3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    imem[0] = '0;
    imem[1] = '0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL mid_we_after_rst: got %b exp 0", dmem_we); end
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL mid_retire_after_rst: got %b exp 0", retire_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_restart_pc: got %h exp 0", imem_addr); end
    @(negedge clk);
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL mid_next_pc: got %h exp 4", imem_addr); end
    run(10);
    checks++; if (s_addr.size() != 0) begin errors++; $display("FAIL mid_no_store: got %0d exp 0", s_addr.size()); end
    checks++; if (q_dst.size() != 0) begin errors++; $display("FAIL mid_no_retire: got %0d exp 0", q_dst.size()); end
    checks++; if (dmem[9] !== 32'h5A5A) begin errors++; $display("FAIL mid_mem_kept: got %h exp 5a5a", dmem[9]); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_store();
    test_zero_reg();
    test_alu_ops();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
